edge_detect_multi: RTL and testbench

- Parametrised multi-channel edge detector.
- Each of WIDTH asynchronous inputs is synchronised, then edge-detected per channel in a selectable mode: off, rising, falling or both.
- Detected edges produce one-cycle pulses, per-channel sticky status bits and a saturating global event count.
- Sits between raw external/cross-domain signals and interrupt/control logic that needs clean single-cycle edge events.

---
 rtl/edge_detect_multi_if.sv | 26 ++
 rtl/edge_detect_multi.sv | 169 ++++++++++++++++
 tb/tb_edge_detect_multi.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_detect_multi_if.sv
// Bus bundle for edge_detect_multi: raw inputs, per-channel controls and edge results.
// The detector uses the slave modport; whoever drives the inputs uses master.
interface edge_detect_multi_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]   signal;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   clr;
  logic               cnt_clr;
  logic [WIDTH-1:0]   detect;
  logic [WIDTH-1:0]   status;
  logic [WIDTH-1:0]   level;
  logic [CNT_W-1:0]   event_cnt;
  logic               armed;

  modport master (
    output signal, mode, clr, cnt_clr,
    input  detect, status, level, event_cnt, armed
  );

  modport slave (
    input  signal, mode, clr, cnt_clr,
    output detect, status, level, event_cnt, armed
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronising edge detector with sticky status and a saturating event counter.
// Optional per-channel glitch filter after the synchroniser: define EDGE_FILTER_EN.
module edge_detect_multi #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILTER_LEN  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  edge_detect_multi_if.slave bus
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("edge_detect_multi: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  // With the filter, level settles FILTER_LEN cycles later, so arming waits that much longer
  // to keep an input held high through reset from producing a false edge.
`ifdef EDGE_FILTER_EN
  localparam int ARM_EDGES = SYNC_STAGES + 1 + FILTER_LEN;
`else
  localparam int ARM_EDGES = SYNC_STAGES + 1;
`endif
  localparam int ACW   = $clog2(ARM_EDGES + 1);
  localparam int PCW   = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } arm_state_t;

  arm_state_t       state_reg;
  logic [ACW-1:0]   arm_cnt_reg;
  logic             armed_reg;

  logic [WIDTH-1:0] level_vec;
  logic [WIDTH-1:0] detect_next;
  logic [WIDTH-1:0] detect_vec;
  logic [WIDTH-1:0] status_vec;
  logic [PCW-1:0]   hit_cnt;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic [SUM_W-1:0] sum_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= UNARMED;
      arm_cnt_reg <= '0;
      armed_reg   <= 1'b0;
    end else begin
      case (state_reg)
        UNARMED: begin
          if (arm_cnt_reg == ACW'(ARM_EDGES - 1)) begin
            state_reg <= ARMED;
            armed_reg <= 1'b1;
          end else begin
            arm_cnt_reg <= arm_cnt_reg + 1'b1;
          end
        end
        ARMED: begin
          armed_reg <= 1'b1;
        end
        default: begin
          state_reg <= UNARMED;
          armed_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   sync_level;
    logic                   level_w;
    logic                   prev_reg;
    logic                   detect_reg;
    logic                   status_reg;
    logic                   rise;
    logic                   fall;
    logic                   hit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain_reg <= '0;
      end else begin
        chain_reg <= {chain_reg[SYNC_STAGES-2:0], bus.signal[gi]};
      end
    end
    assign sync_level = chain_reg[SYNC_STAGES-1];

`ifdef EDGE_FILTER_EN
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [FCW-1:0] fcnt_reg;
    logic           filt_reg;

    // Counts consecutive cycles of disagreement; only a run of FILTER_LEN moves the level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fcnt_reg <= '0;
        filt_reg <= 1'b0;
      end else if (sync_level == filt_reg) begin
        fcnt_reg <= '0;
      end else if (fcnt_reg == FCW'(FILTER_LEN - 1)) begin
        fcnt_reg <= '0;
        filt_reg <= sync_level;
      end else begin
        fcnt_reg <= fcnt_reg + 1'b1;
      end
    end
    assign level_w = filt_reg;
`else
    assign level_w = sync_level;
`endif

    assign rise = level_w & ~prev_reg;
    assign fall = ~level_w & prev_reg;
    assign hit  = (bus.mode[2*gi] & rise) | (bus.mode[2*gi+1] & fall);
    assign detect_next[gi] = hit & armed_reg;

    // prev keeps tracking while unarmed so arming never sees a stale level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_reg   <= 1'b0;
        detect_reg <= 1'b0;
        status_reg <= 1'b0;
      end else begin
        prev_reg   <= level_w;
        detect_reg <= detect_next[gi];
        status_reg <= detect_next[gi] | (status_reg & ~bus.clr[gi]);
      end
    end

    assign level_vec[gi]  = level_w;
    assign detect_vec[gi] = detect_reg;
    assign status_vec[gi] = status_reg;
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_cnt = hit_cnt + PCW'(detect_next[i]);
    end
  end

  // A clear that coincides with events restarts from those events rather than from zero.
  assign cnt_base = bus.cnt_clr ? '0 : cnt_reg;
  assign sum_w    = SUM_W'(cnt_base) + SUM_W'(hit_cnt);
  assign cnt_next = (sum_w > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_w[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bus.detect    = detect_vec;
  assign bus.status    = status_vec;
  assign bus.level     = level_vec;
  assign bus.event_cnt = cnt_reg;
  assign bus.armed     = armed_reg;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: directed table, hand sequences and a random run
// against a history-queue reference model. Filter scenarios run when EDGE_FILTER_EN is defined.
module tb_edge_detect_multi;
  localparam int WIDTH      = 4;
  localparam int S          = 2;
  localparam int CNT_W      = 8;
  localparam int SAT_W      = 4;
  localparam int FILTER_LEN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  edge_detect_multi_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  edge_detect_multi_if #(.WIDTH(WIDTH), .CNT_W(SAT_W)) bus_sat ();

  assign bus_sat.signal  = bus.signal;
  assign bus_sat.mode    = bus.mode;
  assign bus_sat.clr     = bus.clr;
  assign bus_sat.cnt_clr = bus.cnt_clr;

  edge_detect_multi #(.WIDTH(WIDTH), .SYNC_STAGES(S), .CNT_W(CNT_W), .FILTER_LEN(FILTER_LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  edge_detect_multi #(.WIDTH(WIDTH), .SYNC_STAGES(S), .CNT_W(SAT_W), .FILTER_LEN(FILTER_LEN)) dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: hist_q[j] holds the input value captured j edges ago.
  logic [WIDTH-1:0] hist_q[$];
  int               k_edges;
  logic [WIDTH-1:0] m_detect, m_status, m_level;
  logic             m_armed;
  int               m_cnt, m_cnt_sat;

  typedef struct packed {
    logic [3:0] sig;
    logic [7:0] mode;
    logic [3:0] clr;
    logic       cclr;
    logic [3:0] det;
    logic [3:0] st;
    logic [3:0] lvl;
    logic [7:0] cnt;
    logic       arm;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int sat_add(input int base, input int add, input int maxv);
    return (base + add > maxv) ? maxv : base + add;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    for (int j = 0; j < S + 2; j++) hist_q.push_back('0);
    k_edges   = 0;
    m_detect  = '0;
    m_status  = '0;
    m_level   = '0;
    m_armed   = 1'b0;
    m_cnt     = 0;
    m_cnt_sat = 0;
  endtask

  task automatic model_step();
    logic [WIDTH-1:0] cur, old, det;
    logic [1:0]       m;
    int               pop;
    hist_q.push_front(bus.signal);
    void'(hist_q.pop_back());
    k_edges++;
    cur = hist_q[S];
    old = hist_q[S+1];
    det = '0;
    if (k_edges >= S + 2) begin
      for (int i = 0; i < WIDTH; i++) begin
        m = bus.mode[2*i +: 2];
        if (cur[i] != old[i]) det[i] = cur[i] ? m[0] : m[1];
      end
    end
    pop       = $countones(det);
    m_detect  = det;
    m_level   = hist_q[S-1];
    m_armed   = (k_edges >= S + 1);
    m_status  = (m_status & ~bus.clr) | det;
    m_cnt     = sat_add(bus.cnt_clr ? 0 : m_cnt, pop, (1 << CNT_W) - 1);
    m_cnt_sat = sat_add(bus.cnt_clr ? 0 : m_cnt_sat, pop, (1 << SAT_W) - 1);
  endtask

  task automatic check_all();
    check("detect", 32'(bus.detect), 32'(m_detect));
    check("status", 32'(bus.status), 32'(m_status));
    check("level", 32'(bus.level), 32'(m_level));
    check("armed", 32'(bus.armed), 32'(m_armed));
    check("event_cnt", 32'(bus.event_cnt), 32'(m_cnt));
    check("event_cnt_sat", 32'(bus_sat.event_cnt), 32'(m_cnt_sat));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
`ifndef EDGE_FILTER_EN
    check_all();
`endif
  endtask

  // Called just after a posedge; asserts reset mid-cycle and releases it on a falling edge.
  task automatic do_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int total, multi, last_pulse, bad_gap, seen, lvl_seen, first;

    bus.signal  = '0;
    bus.mode    = '0;
    bus.clr     = '0;
    bus.cnt_clr = 1'b0;
    model_reset();

    tbl[0]  = '{4'h0, 8'h55, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b0};
    tbl[1]  = '{4'h0, 8'h55, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b0};
    tbl[2]  = '{4'h0, 8'h55, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b1};
    tbl[3]  = '{4'h1, 8'h55, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0, 1'b1};
    tbl[4]  = '{4'h1, 8'h55, 4'h0, 1'b0, 4'h0, 4'h0, 4'h1, 8'd0, 1'b1};
    tbl[5]  = '{4'h1, 8'h55, 4'h0, 1'b0, 4'h1, 4'h1, 4'h1, 8'd1, 1'b1};
    tbl[6]  = '{4'h1, 8'h55, 4'h0, 1'b0, 4'h0, 4'h1, 4'h1, 8'd1, 1'b1};
    tbl[7]  = '{4'h0, 8'h55, 4'h0, 1'b0, 4'h0, 4'h1, 4'h1, 8'd1, 1'b1};
    tbl[8]  = '{4'h0, 8'h55, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 8'd1, 1'b1};
    tbl[9]  = '{4'h0, 8'h55, 4'h0, 1'b0, 4'h0, 4'h1, 4'h0, 8'd1, 1'b1};
    tbl[10] = '{4'h0, 8'h55, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 8'd1, 1'b1};
    tbl[11] = '{4'h0, 8'h56, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 8'd0, 1'b1};

    // Power-on reset; inputs held high with both-edge mode through release.
    repeat (3) @(posedge clk);
    #1;
    check_all();
    bus.signal = 4'hF;
    bus.mode   = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;

`ifndef EDGE_FILTER_EN
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("hold_armed_e%0d", c), 32'(bus.armed), (c >= 3) ? 32'd1 : 32'd0);
      check($sformatf("hold_detect_e%0d", c), 32'(bus.detect), 32'd0);
    end
    check("hold_status", 32'(bus.status), 32'd0);
    check("hold_cnt", 32'(bus.event_cnt), 32'd0);

    // Directed table: rising mode on ch0, sticky clear, counter clear, mode change.
    bus.signal = '0;
    do_reset(2);
    for (int r = 0; r < 12; r++) begin
      bus.signal  = tbl[r].sig;
      bus.mode    = tbl[r].mode;
      bus.clr     = tbl[r].clr;
      bus.cnt_clr = tbl[r].cclr;
      tick();
      check($sformatf("tbl%0d_detect", r), 32'(bus.detect), 32'(tbl[r].det));
      check($sformatf("tbl%0d_status", r), 32'(bus.status), 32'(tbl[r].st));
      check($sformatf("tbl%0d_level", r), 32'(bus.level), 32'(tbl[r].lvl));
      check($sformatf("tbl%0d_cnt", r), 32'(bus.event_cnt), 32'(tbl[r].cnt));
      check($sformatf("tbl%0d_armed", r), 32'(bus.armed), 32'(tbl[r].arm));
    end
    bus.clr     = '0;
    bus.cnt_clr = 1'b0;

    // Both-edge mode, all channels toggling every 10 clocks.
    bus.mode   = 8'hFF;
    bus.signal = '0;
    repeat (5) tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    total = 0; multi = 0; last_pulse = -1; bad_gap = 0;
    for (int t = 0; t < 8; t++) begin
      bus.signal = (t % 2 == 0) ? 4'hF : 4'h0;
      for (int c = 0; c < 10; c++) begin
        tick();
        total += $countones(bus.detect);
        if ($countones(bus.detect) >= 2) multi++;
        if (bus.detect[0]) begin
          if (last_pulse >= 0 && (t * 10 + c - last_pulse) != 10) bad_gap++;
          last_pulse = t * 10 + c;
        end
      end
    end
    repeat (5) begin
      tick();
      total += $countones(bus.detect);
    end
    check("toggle_pulses", 32'(total), 32'd32);
    check("toggle_cnt", 32'(bus.event_cnt), 32'd32);
    check("toggle_multi_cycles", 32'(multi), 32'd8);
    check("toggle_gap", 32'(bad_gap), 32'd0);
    check("toggle_cnt_sat", 32'(bus_sat.event_cnt), 32'd15);

    // Sticky clear racing a new event on ch1.
    bus.clr = 4'hF;
    tick();
    bus.clr    = '0;
    bus.signal = 4'b0010;
    tick();
    tick();
    bus.clr = 4'b0010;
    tick();
    check("race_detect1", 32'(bus.detect[1]), 32'd1);
    check("race_status1", 32'(bus.status[1]), 32'd1);
    bus.clr = '0;
    tick();
    check("race_status1_hold", 32'(bus.status[1]), 32'd1);
    bus.clr = 4'b0010;
    tick();
    check("race_status1_clr", 32'(bus.status[1]), 32'd0);
    bus.clr = '0;

    // Saturation: 20 events, then a counter clear coinciding with two events.
    bus.signal = '0;
    repeat (4) tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    for (int t = 0; t < 5; t++) begin
      bus.signal = (t % 2 == 0) ? 4'hF : 4'h0;
      repeat (4) tick();
    end
    check("sat_cnt_main", 32'(bus.event_cnt), 32'd20);
    check("sat_cnt_4bit", 32'(bus_sat.event_cnt), 32'd15);
    bus.signal = bus.signal ^ 4'b0011;
    tick();
    tick();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("cclr_coinc_detect", 32'(bus.detect), 32'h3);
    check("cclr_coinc_cnt", 32'(bus.event_cnt), 32'd2);
    check("cclr_coinc_cnt_sat", 32'(bus_sat.event_cnt), 32'd2);

    // Random run with a reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) bus.signal = bus.signal ^ WIDTH'($urandom);
      if ($urandom_range(0, 39) == 0) bus.mode = 8'($urandom);
      bus.clr     = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : '0;
      bus.cnt_clr = ($urandom_range(0, 99) == 0);
      if (n == 700) do_reset(3);
      tick();
    end
`else
    // Filter scenarios: ch2 in rising mode.
    bus.signal = '0;
    bus.mode   = 8'h10;
    repeat (12) tick();
    bus.signal = 4'b0100;
    repeat (2) tick();
    bus.signal = '0;
    seen = 0; lvl_seen = 0;
    repeat (12) begin
      tick();
      if (bus.detect[2]) seen++;
      if (bus.level[2]) lvl_seen++;
    end
    check("filt_short_detect", 32'(seen), 32'd0);
    check("filt_short_level", 32'(lvl_seen), 32'd0);
    bus.signal = 4'b0100;
    seen = 0; first = -1;
    for (int t = 0; t < 16; t++) begin
      if (t == 5) bus.signal = '0;
      tick();
      if (bus.detect[2]) begin
        seen++;
        if (first < 0) first = t;
      end
    end
    check("filt_long_pulses", 32'(seen), 32'd1);
    check("filt_long_latency", 32'(first), 32'(S + FILTER_LEN));
    check("filt_long_cnt", 32'(bus.event_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
